// File: rtl/pipe_pkg.sv
// Shared types and constants for the program-order pipeline tracker.
// Entry layout is {valid, pc, instr}; invalid entries are all zero.
package pipe_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int STAGES_DEF  = 5;

  typedef struct packed {
    logic                   valid;
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } pipe_entry_t;

  localparam pipe_entry_t BUBBLE = '0;

  function automatic bit stages_ok(int stages);
    return stages >= 2;
  endfunction

  function automatic bit depth_ok(int stages, int depth);
    return (depth >= 1) && (depth <= stages - 1);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One tracker entry: kill beats hold, hold beats load.
// An invalid loaded entry is forced to all zero.
module pipe_stage_reg #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         kill,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (kill) begin
      q <= '0;
    end else if (!hold) begin
      q <= d[W-1] ? d : '0;
    end
  end

endmodule

// File: rtl/pipe_track_chain.sv
// N-stage {valid, pc, instr} tracker with freeze bubbles and flush kill.
// Define PIPE_STATS_EN to add saturating retired/bubble counters.
module pipe_track_chain
  import pipe_pkg::*;
#(
  parameter int PC_W         = PC_W_DEF,
  parameter int INSTR_W      = INSTR_W_DEF,
  parameter int STAGES       = STAGES_DEF,
  parameter int FREEZE_DEPTH = 2,
  parameter int FLUSH_DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [PC_W-1:0]             in_pc,
  input  logic [INSTR_W-1:0]          in_instr,
  output logic                        in_ready,
  input  logic                        freeze,
  input  logic                        flush,
  output logic                        out_valid,
  output logic [PC_W-1:0]             out_pc,
  output logic [INSTR_W-1:0]          out_instr,
  output logic [$clog2(STAGES+1)-1:0] occupancy
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0]                 retired_cnt,
  output logic [31:0]                 bubble_cnt
`endif
);

  localparam int W     = 1 + PC_W + INSTR_W;
  localparam int OCC_W = $clog2(STAGES + 1);

  if (!stages_ok(STAGES)) begin : g_bad_stages
    $error("pipe_track_chain: STAGES must be >= 2");
  end
  if (!depth_ok(STAGES, FREEZE_DEPTH)) begin : g_bad_freeze
    $error("pipe_track_chain: FREEZE_DEPTH out of range");
  end
  if (!depth_ok(STAGES, FLUSH_DEPTH)) begin : g_bad_flush
    $error("pipe_track_chain: FLUSH_DEPTH out of range");
  end

  logic [W-1:0]      d [STAGES];
  logic [W-1:0]      q [STAGES];
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] kill;
  logic              frz_eff;
  logic [OCC_W-1:0]  occ_nxt;

  // Flush wins over freeze in the same cycle.
  assign frz_eff  = freeze & ~flush;
  assign in_ready = ~freeze | flush;

  always_comb begin
    hold = '0;
    kill = '0;
    unique case (1'b1)
      flush: begin
        for (int i = 0; i < STAGES; i++) begin
          kill[i] = (i < FLUSH_DEPTH);
        end
      end
      frz_eff: begin
        for (int i = 0; i < STAGES; i++) begin
          hold[i] = (i < FREEZE_DEPTH);
          kill[i] = (i == FREEZE_DEPTH);
        end
      end
      default: ;
    endcase
  end

  assign d[0] = {in_valid, in_pc, in_instr};

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i > 0) begin : g_link
      assign d[i] = q[i-1];
    end
    pipe_stage_reg #(
      .W(W)
    ) u_reg (
      .clk  (clk),
      .rst  (rst),
      .hold (hold[i]),
      .kill (kill[i]),
      .d    (d[i]),
      .q    (q[i])
    );
  end

  assign {out_valid, out_pc, out_instr} = q[STAGES-1];

  // Count the valid bits each stage will hold after the edge.
  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (!kill[i]) begin
        if (hold[i]) begin
          occ_nxt = occ_nxt + OCC_W'(q[i][W-1]);
        end else begin
          occ_nxt = occ_nxt + OCC_W'(d[i][W-1]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_nxt;
    end
  end

`ifdef PIPE_STATS_EN
  logic [OCC_W-1:0] warm;
  logic             warm_done;

  assign warm_done = (warm == OCC_W'(STAGES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm        <= '0;
      retired_cnt <= '0;
      bubble_cnt  <= '0;
    end else begin
      if (!warm_done) begin
        warm <= warm + OCC_W'(1);
      end
      if (out_valid && retired_cnt != '1) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      if (!out_valid && warm_done && bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_track_chain.sv
// Directed bench for pipe_track_chain (STAGES=5, depths 2/2).
// Stats counters are exercised when PIPE_STATS_EN is defined.
module tb_pipe_track_chain;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  occupancy;
`ifdef PIPE_STATS_EN
  logic [31:0] retired_cnt;
  logic [31:0] bubble_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_track_chain #(
    .PC_W         (32),
    .INSTR_W      (32),
    .STAGES       (5),
    .FREEZE_DEPTH (2),
    .FLUSH_DEPTH  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .freeze      (freeze),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
`ifdef PIPE_STATS_EN
    .retired_cnt (retired_cnt),
    .bubble_cnt  (bubble_cnt),
`endif
    .occupancy   (occupancy)
  );

  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step(logic v, logic [31:0] pc, logic frz,
                      logic fl, logic rdy);
    in_valid = v;
    in_pc    = pc;
    in_instr = v ? instr_of(pc) : 32'hFFFF_FFFF;
    freeze   = frz;
    flush    = fl;
    #1 check("in_ready", 64'(in_ready), 64'(rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(string tag, logic v, logic [31:0] pc, int occ);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".pc"}, 64'(out_pc), 64'(v ? pc : 32'd0));
    check({tag, ".instr"}, 64'(out_instr),
          64'(v ? instr_of(pc) : 32'd0));
    check({tag, ".occ"}, 64'(occupancy), 64'(occ));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 32'd0, 0);
    check("reset.in_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_STATS_EN
    check("reset.retired", 64'(retired_cnt), 64'd0);
    check("reset.bubble", 64'(bubble_cnt), 64'd0);
`endif
    rst = 1'b1;

    // fill: output stays empty for four edges
    step(1, 32'd0, 0, 0, 1);  expect_out("e1", 0, 0, 1);
    step(1, 32'd4, 0, 0, 1);  expect_out("e2", 0, 0, 2);
    step(1, 32'd8, 0, 0, 1);  expect_out("e3", 0, 0, 3);
    step(1, 32'd12, 0, 0, 1); expect_out("e4", 0, 0, 4);
    step(1, 32'd16, 0, 0, 1); expect_out("e5", 1, 0, 5);
    step(1, 32'd20, 0, 0, 1); expect_out("e6", 1, 4, 5);
    // single freeze: 24 not consumed, bubble into s2
    step(1, 32'd24, 1, 0, 0); expect_out("e7", 1, 8, 4);
    step(1, 32'd24, 0, 0, 1); expect_out("e8", 1, 12, 4);
    // flush: s0/s1 killed, 28 discarded
    step(1, 32'd28, 0, 1, 1); expect_out("e9", 0, 0, 2);
    step(1, 32'd32, 0, 0, 1); expect_out("e10", 1, 16, 3);
    step(1, 32'd36, 0, 0, 1); expect_out("e11", 1, 20, 3);
    step(1, 32'd40, 0, 0, 1); expect_out("e12", 0, 0, 3);
    step(1, 32'd44, 0, 0, 1); expect_out("e13", 0, 0, 4);
    step(1, 32'd48, 0, 0, 1); expect_out("e14", 1, 32, 5);
    // flush and freeze together behave as flush
    step(1, 32'd52, 1, 1, 1); expect_out("e15", 1, 36, 3);
    step(1, 32'd56, 0, 0, 1); expect_out("e16", 1, 40, 3);
    // long freeze drains the back end
    step(1, 32'd60, 1, 0, 0); expect_out("e17", 1, 44, 2);
    step(1, 32'd60, 1, 0, 0); expect_out("e18", 0, 0, 1);
    step(1, 32'd60, 1, 0, 0); expect_out("e19", 0, 0, 1);
    step(1, 32'd60, 0, 0, 1); expect_out("e20", 0, 0, 2);

    // asynchronous reset between edges
    freeze = 1'b1;
    #2 rst = 1'b0;
    #1;
    expect_out("midrst", 0, 0, 0);
    check("midrst.in_ready_frz", 64'(in_ready), 64'd0);
    freeze = 1'b0;
    #1;
    check("midrst.in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;

    step(1, 32'd100, 0, 0, 1);          expect_out("r1", 0, 0, 1);
    step(0, 32'hFFFF_FFF0, 0, 0, 1);    expect_out("r2", 0, 0, 1);
    step(0, 32'hFFFF_FFF0, 0, 0, 1);    expect_out("r3", 0, 0, 1);
    step(0, 32'hFFFF_FFF0, 0, 0, 1);    expect_out("r4", 0, 0, 1);
    step(0, 32'hFFFF_FFF0, 0, 0, 1);    expect_out("r5", 1, 100, 1);
    step(0, 32'hFFFF_FFF0, 0, 0, 1);    expect_out("r6", 0, 0, 0);

`ifdef PIPE_STATS_EN
    rst = 1'b0;
    #1;
    check("st.rst_retired", 64'(retired_cnt), 64'd0);
    check("st.rst_bubble", 64'(bubble_cnt), 64'd0);
    #1 rst = 1'b1;
    step(1, 32'd0, 0, 0, 1);
    step(1, 32'd4, 0, 0, 1);
    step(1, 32'd8, 0, 0, 1);
    step(1, 32'd12, 1, 0, 0);
    step(1, 32'd12, 0, 0, 1);
    step(1, 32'd16, 0, 0, 1);
    step(1, 32'd20, 0, 1, 1);
    step(1, 32'd24, 0, 0, 1);
    step(1, 32'd28, 0, 0, 1);
    step(1, 32'd32, 0, 0, 1);
    step(1, 32'd36, 0, 0, 1);
    expect_out("st.e11", 0, 0, 4);
    for (int i = 0; i < 5; i++) step(0, 32'd0, 0, 0, 1);
    check("st.retired", 64'(retired_cnt), 64'd8);
    check("st.bubble", 64'(bubble_cnt), 64'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
